// File: rtl/mux_key_table_pkg.sv
// Shared constants and helpers for the key lookup table: counter width,
// saturation limit and the entry-index width derivation.
package mux_key_table_pkg;

   localparam int unsigned CNT_W = 32;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/mux_key_table_prio_enc.sv
// Lowest-index priority encoder over the per-entry match vector.
// Reports whether any entry matched and the index of the lowest one (0 if none).
module mux_key_prio_enc
   import mux_key_table_pkg::*;
#(
   parameter  int unsigned NR_KEY = 8,
   localparam int unsigned IDX_W  = idx_width(NR_KEY)
) (
   input  logic [NR_KEY-1:0] match,
   output logic              any,
   output logic [IDX_W-1:0]  idx
);

   // Scan from the top down so the lowest matching entry is the last one written.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int unsigned i = NR_KEY; i > 0; i--) begin
         if (match[i-1]) begin
            any = 1'b1;
            idx = IDX_W'(i - 1);
         end
      end
   end

endmodule

// File: rtl/mux_key_table.sv
// Runtime-programmable key->data lookup table with a registered, handshaked
// response port, programmable miss default and saturating hit/miss statistics.
module mux_key_table
   import mux_key_table_pkg::*;
#(
   parameter  int unsigned         NR_KEY      = 8,
   parameter  int unsigned         KEY_LEN     = 7,
   parameter  int unsigned         DATA_LEN    = 32,
   parameter  logic [DATA_LEN-1:0] DEFAULT_VAL = '0,
   localparam int unsigned         IDX_W       = idx_width(NR_KEY)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [IDX_W-1:0]    wr_idx,
   input  logic [KEY_LEN-1:0]  wr_key,
   input  logic [DATA_LEN-1:0] wr_data,
   input  logic                inv_en,
   input  logic [IDX_W-1:0]    inv_idx,
   input  logic                flush,
   input  logic                def_wr_en,
   input  logic [DATA_LEN-1:0] def_data,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [KEY_LEN-1:0]  req_key,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_LEN-1:0] rsp_data,
   output logic                rsp_hit,
   output logic [IDX_W-1:0]    rsp_idx,
   output logic [CNT_W-1:0]    hit_cnt,
   output logic [CNT_W-1:0]    miss_cnt,
   input  logic                stat_clr
);

   logic [NR_KEY-1:0]   valid_q;
   logic [KEY_LEN-1:0]  key_q  [NR_KEY];
   logic [DATA_LEN-1:0] data_q [NR_KEY];
   logic [DATA_LEN-1:0] def_q;

   logic [NR_KEY-1:0]   match;
   logic                hit_any;
   logic [IDX_W-1:0]    hit_idx;
   logic                accept;

   logic                rsp_valid_q;
   logic [DATA_LEN-1:0] rsp_data_q;
   logic                rsp_hit_q;
   logic [IDX_W-1:0]    rsp_idx_q;
   logic [CNT_W-1:0]    hit_q;
   logic [CNT_W-1:0]    miss_q;

   always_comb begin
      match = '0;
      for (int unsigned i = 0; i < NR_KEY; i++) begin
         match[i] = valid_q[i] && (key_q[i] == req_key);
      end
   end

   mux_key_prio_enc #(
      .NR_KEY(NR_KEY)
   ) u_prio_enc (
      .match(match),
      .any  (hit_any),
      .idx  (hit_idx)
   );

   assign req_ready = !rsp_valid_q || rsp_ready;
   assign accept    = req_valid && req_ready;

   // Clear before set: a write in the same edge as flush/invalidate leaves the
   // entry valid. Out-of-range indices never compare equal, so they are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         for (int unsigned i = 0; i < NR_KEY; i++) begin
            key_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NR_KEY; i++) begin
            if (flush || (inv_en && (inv_idx == IDX_W'(i)))) valid_q[i] <= 1'b0;
            if (wr_en && (wr_idx == IDX_W'(i))) begin
               valid_q[i] <= 1'b1;
               key_q[i]   <= wr_key;
               data_q[i]  <= wr_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) def_q <= DEFAULT_VAL;
      else if (def_wr_en) def_q <= def_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_hit_q   <= 1'b0;
         rsp_idx_q   <= '0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         rsp_hit_q   <= hit_any;
         rsp_idx_q   <= hit_idx;
         rsp_data_q  <= hit_any ? data_q[hit_idx] : def_q;
      end else if (rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (stat_clr) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else if (accept) begin
         if (hit_any) hit_q  <= sat_inc(hit_q);
         else         miss_q <= sat_inc(miss_q);
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_idx   = rsp_idx_q;
   assign hit_cnt   = hit_q;
   assign miss_cnt  = miss_q;

endmodule
